// File: rtl/probador_mux_param.sv
// Self-checking stimulus generator for N-channel mux DUTs: drives exhaustive or
// LFSR vectors, predicts the mux output, aligns it to the DUT latency and counts mismatches.
module probador_mux_param #(
    parameter int          DATA_W  = 1,
    parameter int          N_CH    = 2,
    parameter int          LAT     = 1,
    parameter int          NUM_VEC = 16,
    parameter logic [15:0] SEED    = 16'd1,
    parameter logic [15:0] TAPS    = 16'hB,
    parameter int          ERR_W   = 8,
    localparam int         SEL_W   = (N_CH > 2) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic                     start,
    input  logic                     mode,
    input  logic [DATA_W-1:0]        dut_out,
    output logic [N_CH*DATA_W-1:0]   data_in,
    output logic [SEL_W-1:0]         selector,
    output logic                     vec_valid,
    output logic [DATA_W-1:0]        exp_out,
    output logic [ERR_W-1:0]         err_cnt,
    output logic                     busy,
    output logic                     done,
    output logic                     pass
);

    localparam int             DW_ALL     = N_CH * DATA_W;
    localparam int             VW         = SEL_W + DW_ALL;
    localparam logic [VW-1:0]  SEED_V     = SEED[VW-1:0];
    localparam logic [VW-1:0]  TAPS_V     = TAPS[VW-1:0];
    localparam logic [2:0]     DRAIN_INIT = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            stateReg;
    state_t            stateNext;
    logic [VW-1:0]     vecReg;
    logic [VW-1:0]     lfsrNext;
    logic              vecValidReg;
    logic              modeReg;
    logic [15:0]       vecCount;
    logic [2:0]        drainCnt;
    logic [ERR_W-1:0]  errReg;
    logic              startOk;
    logic              lastVec;
    logic [DATA_W-1:0] expNow;
    logic [DATA_W-1:0] chkExp;
    logic              chkValid;

    assign startOk  = start && ((stateReg == IDLE) || (stateReg == DONE));
    assign lfsrNext = (vecReg >> 1) ^ (vecReg[0] ? TAPS_V : '0);
    // vecCount counts vectors already issued, including the one on the outputs now
    assign lastVec  = modeReg ? (vecCount == 16'(NUM_VEC)) : (vecReg == {VW{1'b1}});

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE, DONE: if (startOk) stateNext = RUN;
            RUN:        if (lastVec) stateNext = (LAT == 0) ? DONE : DRAIN;
            DRAIN:      if (drainCnt == 3'd0) stateNext = DONE;
            default:    stateNext = IDLE;
        endcase
    end

    always_comb begin
        busy = (stateReg == RUN) || (stateReg == DRAIN);
        done = (stateReg == DONE);
        pass = (stateReg == DONE) && (errReg == '0);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            vecReg      <= '0;
            vecValidReg <= 1'b0;
            modeReg     <= 1'b0;
            vecCount    <= '0;
            drainCnt    <= '0;
        end else if (startOk) begin
            vecReg      <= mode ? SEED_V : '0;
            vecValidReg <= 1'b1;
            modeReg     <= mode;
            vecCount    <= 16'd1;
        end else if (stateReg == RUN) begin
            if (lastVec) begin
                // the last vector stays on data_in/selector, only marked invalid
                vecValidReg <= 1'b0;
                drainCnt    <= DRAIN_INIT;
            end else begin
                vecReg   <= modeReg ? lfsrNext : vecReg + 1'b1;
                vecCount <= vecCount + 16'd1;
            end
        end else if ((stateReg == DRAIN) && (drainCnt != 3'd0)) begin
            drainCnt <= drainCnt - 3'd1;
        end
    end

    assign data_in   = vecReg[DW_ALL-1:0];
    assign selector  = vecReg[VW-1:DW_ALL];
    assign vec_valid = vecValidReg;

    // unused selector codes (selector >= N_CH) predict 0
    always_comb begin
        expNow = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (selector == SEL_W'(i)) expNow = data_in[i*DATA_W +: DATA_W];
        end
    end

    generate
        if (LAT == 0) begin : g_nopipe
            assign chkExp   = expNow;
            assign chkValid = vecValidReg;
        end else begin : g_pipe
            logic [DATA_W-1:0] expPipe [LAT];
            logic [LAT-1:0]    validPipe;

            always_ff @(posedge clk or negedge reset_L) begin
                if (!reset_L) begin
                    validPipe <= '0;
                    for (int i = 0; i < LAT; i++) expPipe[i] <= '0;
                end else begin
                    expPipe[0]   <= expNow;
                    validPipe[0] <= vecValidReg;
                    for (int i = 1; i < LAT; i++) begin
                        expPipe[i]   <= expPipe[i-1];
                        validPipe[i] <= validPipe[i-1];
                    end
                end
            end

            assign chkExp   = expPipe[LAT-1];
            assign chkValid = validPipe[LAT-1];
        end
    endgenerate

    assign exp_out = chkValid ? chkExp : '0;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            errReg <= '0;
        end else if (startOk) begin
            errReg <= '0;
        end else if (chkValid && (dut_out != chkExp) && (errReg != {ERR_W{1'b1}})) begin
            errReg <= errReg + 1'b1;
        end
    end

    assign err_cnt = errReg;

endmodule
